// File: rtl/exception_sequencer_pkg.sv
// Shared types for the trap sequencer: FSM state encoding and cause codes.
package cpu_exc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    VEC_RD,
    WAIT,
    LOAD_PC
  } exc_state_t;

  localparam int unsigned CAUSE_ILLEGAL = 0;
  localparam int unsigned CAUSE_OVF     = 1;

endpackage

// File: rtl/exception_sequencer_if.sv
// Trap-sequencer bundle between main control / data memory and the sequencer.
interface exception_sequencer_if #(
  parameter int DATA_W = 64
);
  logic              exc_illegal;
  logic              exc_ovf;
  logic [DATA_W-1:0] pc_cur;
  logic              busy;
  logic              done;
  logic              epc_wr;
  logic [DATA_W-1:0] epc_data;
  logic              cause_wr;
  logic [DATA_W-1:0] cause_data;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              pc_wr;
  logic [DATA_W-1:0] pc_data;

  modport master (
    input  exc_illegal, exc_ovf, pc_cur, mem_rdata,
    output busy, done, epc_wr, epc_data, cause_wr, cause_data,
           mem_rd, mem_addr, pc_wr, pc_data
  );

  modport slave (
    output exc_illegal, exc_ovf, pc_cur, mem_rdata,
    input  busy, done, epc_wr, epc_data, cause_wr, cause_data,
           mem_rd, mem_addr, pc_wr, pc_data
  );
endinterface

// File: rtl/exception_sequencer.sv
// Multicycle trap sequencer: EPC/cause write, handler fetch, PC load; done at N+3+MEM_LAT.
// EXC_VECTORED_EN selects one handler pointer per cause instead of a shared one.
module exception_sequencer
  import cpu_exc_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                MEM_LAT  = 2,
  parameter logic [DATA_W-1:0] VEC_BASE = 'd256
) (
  input  logic                   clock,
  input  logic                   reset,
  exception_sequencer_if.master  exc_bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  exc_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] pcd_q, pcd_d;

  logic busy, done, epc_wr, cause_wr, mem_rd, pc_wr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    addr_d   = addr_q;
    pcd_d    = pcd_q;
    busy     = 1'b0;
    done     = 1'b0;
    epc_wr   = 1'b0;
    cause_wr = 1'b0;
    mem_rd   = 1'b0;
    pc_wr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (exc_bus.exc_illegal || exc_bus.exc_ovf) begin
          epc_d   = exc_bus.pc_cur;
          cause_d = exc_bus.exc_illegal ? DATA_W'(CAUSE_ILLEGAL) : DATA_W'(CAUSE_OVF);
`ifdef EXC_VECTORED_EN
          addr_d  = VEC_BASE + (cause_d << 3);
`else
          addr_d  = VEC_BASE;
`endif
          state_d = SAVE;
        end
      end
      SAVE: begin
        busy     = 1'b1;
        epc_wr   = 1'b1;
        cause_wr = 1'b1;
        state_d  = VEC_RD;
      end
      VEC_RD: begin
        busy    = 1'b1;
        mem_rd  = 1'b1;
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        // Read data is valid on the edge that drains the latency counter.
        if (cnt_q == CNT_W'(1)) begin
          pcd_d   = exc_bus.mem_rdata;
          state_d = LOAD_PC;
        end
      end
      LOAD_PC: begin
        busy    = 1'b1;
        pc_wr   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      addr_q  <= '0;
      pcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      pcd_q   <= pcd_d;
    end
  end

  assign exc_bus.busy       = busy;
  assign exc_bus.done       = done;
  assign exc_bus.epc_wr     = epc_wr;
  assign exc_bus.epc_data   = epc_q;
  assign exc_bus.cause_wr   = cause_wr;
  assign exc_bus.cause_data = cause_q;
  assign exc_bus.mem_rd     = mem_rd;
  assign exc_bus.mem_addr   = addr_q;
  assign exc_bus.pc_wr      = pc_wr;
  assign exc_bus.pc_data    = pcd_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench: two sequencers (MEM_LAT 2 and 4) against a latency-modelled data memory.
module tb_exception_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  exception_sequencer_if #(.DATA_W(64)) b0 ();
  exception_sequencer_if #(.DATA_W(64)) b1 ();

  exception_sequencer #(.DATA_W(64), .MEM_LAT(2), .VEC_BASE(64'd256)) u0 (
    .clock(clock), .reset(reset), .exc_bus(b0));
  exception_sequencer #(.DATA_W(64), .MEM_LAT(4), .VEC_BASE(64'd256)) u1 (
    .clock(clock), .reset(reset), .exc_bus(b1));

  typedef struct packed {
    logic        busy, done, epc_wr, cause_wr, mem_rd, pc_wr;
    logic [63:0] epc_data, cause_data, mem_addr, pc_data;
  } obs_t;

  typedef struct {
    int          dut;
    int          n;
    logic [63:0] epc, cause, addr, pcd;
  } exp_t;

  exp_t sb[$];
  exp_t cur[2];
  logic act[2]   = '{1'b0, 1'b0};
  logic rdseen[2] = '{1'b0, 1'b0};
  int   rd_run0 = 0;
  int   rd_run1 = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (a == 64'd256) return 64'h1000;
    if (a == 64'd264) return 64'h2000;
    return a ^ 64'hA5A5_0000;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  // Memory answers only once the read has been held for the full latency.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_run0 <= 0;
      rd_run1 <= 0;
    end else begin
      rd_run0 <= b0.mem_rd ? rd_run0 + 1 : 0;
      rd_run1 <= b1.mem_rd ? rd_run1 + 1 : 0;
    end
  end
  always_comb b0.mem_rdata = (rd_run0 >= 2) ? mem_val(b0.mem_addr) : 64'hBAD0_BAD0;
  always_comb b1.mem_rdata = (rd_run1 >= 4) ? mem_val(b1.mem_addr) : 64'hBAD0_BAD0;

  always @(negedge clock) begin
    obs_t ob[2];
    int   idx;
    ob[0] = {b0.busy, b0.done, b0.epc_wr, b0.cause_wr, b0.mem_rd, b0.pc_wr,
             b0.epc_data, b0.cause_data, b0.mem_addr, b0.pc_data};
    ob[1] = {b1.busy, b1.done, b1.epc_wr, b1.cause_wr, b1.mem_rd, b1.pc_wr,
             b1.epc_data, b1.cause_data, b1.mem_addr, b1.pc_data};
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        act[d] = 1'b0;
      end else begin
        if (ob[d].epc_wr) begin
          idx = -1;
          foreach (sb[i]) if (idx < 0 && sb[i].dut == d) idx = i;
          if (idx < 0) begin
            check_val($sformatf("epc_wr_unexpected%0d", d), 64'(ob[d].epc_wr), 64'd0);
          end else begin
            cur[d] = sb[idx];
            sb.delete(idx);
            act[d] = 1'b1;
            rdseen[d] = 1'b0;
            check_val($sformatf("epc_data%0d", d), ob[d].epc_data, cur[d].epc);
            check_val($sformatf("cause_data%0d", d), ob[d].cause_data, cur[d].cause);
            check_val($sformatf("save_strobes%0d", d), {62'd0, ob[d].cause_wr, ob[d].busy}, 64'd3);
            check_val($sformatf("epc_cycle%0d", d), 64'(cyc), 64'(cur[d].n));
          end
        end
        if (ob[d].mem_rd) begin
          if (!act[d]) begin
            check_val($sformatf("mem_rd_unexpected%0d", d), 64'(ob[d].mem_rd), 64'd0);
          end else begin
            check_val($sformatf("mem_addr%0d", d), ob[d].mem_addr, cur[d].addr);
            if (!rdseen[d]) begin
              rdseen[d] = 1'b1;
              check_val($sformatf("rd_cycle%0d", d), 64'(cyc), 64'(cur[d].n + 1));
            end
          end
        end
        if (ob[d].pc_wr || ob[d].done) begin
          check_val($sformatf("done_eq_pcwr%0d", d), 64'(ob[d].done), 64'(ob[d].pc_wr));
          if (!act[d]) begin
            check_val($sformatf("pc_wr_unexpected%0d", d), 64'(ob[d].pc_wr), 64'd0);
          end else begin
            check_val($sformatf("pc_data%0d", d), ob[d].pc_data, cur[d].pcd);
            check_val($sformatf("pc_cycle%0d", d), 64'(cyc), 64'(cur[d].n + 2 + lat_of(d)));
            act[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive(input int d, input logic ill, input logic ovf, input logic [63:0] pc);
    if (d == 0) begin
      b0.exc_illegal = ill; b0.exc_ovf = ovf; b0.pc_cur = pc;
    end else begin
      b1.exc_illegal = ill; b1.exc_ovf = ovf; b1.pc_cur = pc;
    end
  endtask

  task automatic push_exp(input int d, input int n, input logic ill, input logic [63:0] pc);
    exp_t e;
    e.dut   = d;
    e.n     = n;
    e.epc   = pc;
    e.cause = ill ? 64'd0 : 64'd1;
`ifdef EXC_VECTORED_EN
    e.addr  = 64'd256 + e.cause * 64'd8;
`else
    e.addr  = 64'd256;
`endif
    e.pcd   = mem_val(e.addr);
    sb.push_back(e);
  endtask

  // Called just after a rising edge; the request is sampled on the next edge.
  task automatic fire(input int d, input logic ill, input logic ovf, input logic [63:0] pc);
    drive(d, ill, ovf, pc);
    push_exp(d, cyc + 1, ill, pc);
    @(posedge clock); #1;
    drive(d, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic wait_done(input int d, output int dc);
    logic got = 1'b0;
    dc = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clock);
      if ((d == 0) ? b0.pc_wr : b1.pc_wr) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    check_val($sformatf("done_seen%0d", d), 64'(got), 64'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    int dc;
    drive(0, 1'b0, 1'b0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_ctrl", {58'd0, b0.busy, b0.done, b0.epc_wr, b0.cause_wr, b0.mem_rd, b0.pc_wr}, 64'd0);
    check_val("rst_data", b0.epc_data | b0.cause_data | b0.mem_addr | b0.pc_data, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    fire(0, 1'b1, 1'b0, 64'h40);   wait_done(0, dc);
    fire(0, 1'b0, 1'b1, 64'h88);   wait_done(0, dc);
    fire(0, 1'b1, 1'b1, 64'h100);  wait_done(0, dc);

    // Overflow pulse while the first trap sits in WAIT must be dropped.
    fire(0, 1'b1, 1'b0, 64'h10);
    repeat (2) begin @(posedge clock); #1; end
    drive(0, 1'b0, 1'b1, 64'h999);
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b0, 64'd0);
    wait_done(0, dc);

    // Request held across done: second SAVE two cycles after done.
    drive(0, 1'b0, 1'b1, 64'h200);
    push_exp(0, cyc + 1, 1'b0, 64'h200);
    wait_done(0, dc);
    push_exp(0, dc + 2, 1'b0, 64'h200);
    repeat (3) begin @(posedge clock); #1; end
    drive(0, 1'b0, 1'b0, 64'd0);
    wait_done(0, dc);

    // Reset in WAIT: outputs clear immediately, the trap is abandoned.
    fire(0, 1'b1, 1'b0, 64'h300);
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    check_val("wait_rst_ctrl", {58'd0, b0.busy, b0.done, b0.epc_wr, b0.cause_wr, b0.mem_rd, b0.pc_wr}, 64'd0);
    check_val("wait_rst_data", b0.epc_data | b0.cause_data | b0.mem_addr | b0.pc_data, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    check_val("idle_after_rst", 64'(b0.busy), 64'd0);
    fire(0, 1'b0, 1'b1, 64'h88);   wait_done(0, dc);

    fire(1, 1'b1, 1'b0, 64'h40);   wait_done(1, dc);
    fire(1, 1'b0, 1'b1, 64'h88);   wait_done(1, dc);

    repeat (4) begin @(posedge clock); #1; end
    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
